// File: rtl/breakout_pkg.sv
// breakout_pkg: constants and state encoding shared by the Breakout ball logic.
//   Playfield geometry, ball/paddle constants, wall margins, and the
//   ball controller state type.
package breakout_pkg;

    localparam int unsigned COORD_W    = 11;   // width of every pixel coordinate
    localparam int unsigned SCREEN_W   = 800;
    localparam int unsigned SCREEN_H   = 600;
    localparam int unsigned BALL_SIZE  = 8;
    localparam int unsigned SPEED      = 2;
    localparam int unsigned PADDLE_X_L = 770;
    localparam int unsigned LIVES      = 3;
    localparam int unsigned MISS_HOLD  = 60;

    // Wall margins: left wall keeps x_l >= 4; top/bottom bounce 1 px early.
    localparam int unsigned WALL_X_MIN    = 4;
    localparam int unsigned WALL_Y_MARGIN = 1;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        MISS  = 2'd2,
        OVER  = 2'd3
    } state_t;

endpackage

// File: rtl/breakout_ball_axis.sv
// breakout_ball_axis: one axis of ball motion (position + direction).
//   clk, reset        : clock, asynchronous active-high reset
//   load, load_pos    : force position (and clear direction to negative)
//   step              : advance SPEED pixels in the current direction, clamped
//                       to [POS_MIN, POS_MAX]
//   set_pos, set_neg  : direction requests; both asserted leaves direction as is
//   pos               : current low-edge position
module breakout_ball_axis
    import breakout_pkg::*;
#(
    parameter int unsigned POS_INIT = 0,
    parameter int unsigned POS_MIN  = 0,
    parameter int unsigned POS_MAX  = 2047,
    parameter int unsigned STEP     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [COORD_W-1:0] load_pos,
    input  logic               step,
    input  logic               set_pos,
    input  logic               set_neg,
    output logic [COORD_W-1:0] pos
);

    logic               dir;
    logic [COORD_W:0]   up_sum;
    logic [COORD_W-1:0] pos_next;

    // One extra bit so an upward step near the top of the range cannot wrap.
    assign up_sum = {1'b0, pos} + (COORD_W + 1)'(STEP);

    always_comb begin
        pos_next = pos;
        if (dir) begin
            pos_next = (up_sum > (COORD_W + 1)'(POS_MAX)) ? COORD_W'(POS_MAX)
                                                          : up_sum[COORD_W-1:0];
        end else begin
            pos_next = (pos < COORD_W'(POS_MIN + STEP)) ? COORD_W'(POS_MIN)
                                                        : pos - COORD_W'(STEP);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos <= COORD_W'(POS_INIT);
            dir <= 1'b0;
        end else if (load) begin
            pos <= load_pos;
            dir <= 1'b0;
        end else begin
            if (step) begin
                pos <= pos_next;
            end
            if (set_pos && !set_neg) begin
                dir <= 1'b1;
            end else if (set_neg && !set_pos) begin
                dir <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/breakout_ball_ctrl.sv
// breakout_ball_ctrl: ball position/direction, bounces, serve, misses, lives.
//   clk, reset                 : clock, asynchronous active-high reset
//   tick                       : frame strobe; ball moves only on tick
//   launch                     : serve button (level)
//   hitU/hitD/hitL/hitR        : OR of all block columns' move requests
//   paddle_y_t, paddle_y_b     : paddle vertical extent
//   pix_x, pix_y               : current scan pixel
//   ball_x_l/x_r/y_t/y_b       : ball edges
//   ball_ON                    : scan pixel is inside a visible ball
//   lives                      : remaining lives
//   game_over                  : high in OVER
module breakout_ball_ctrl
    import breakout_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               launch,
    input  logic               hitU,
    input  logic               hitD,
    input  logic               hitL,
    input  logic               hitR,
    input  logic [COORD_W-1:0] paddle_y_t,
    input  logic [COORD_W-1:0] paddle_y_b,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic [COORD_W-1:0] ball_x_l,
    output logic [COORD_W-1:0] ball_x_r,
    output logic [COORD_W-1:0] ball_y_t,
    output logic [COORD_W-1:0] ball_y_b,
    output logic               ball_ON,
    output logic [2:0]         lives,
    output logic               game_over
);

    localparam int unsigned HOLD_W = $clog2(MISS_HOLD + 1);
    localparam logic [COORD_W-1:0] SERVE_X = COORD_W'(PADDLE_X_L - BALL_SIZE - 2);

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [COORD_W-1:0]  x_l, x_r, y_t, y_b;
    logic [COORD_W:0]    paddle_sum;
    logic [COORD_W-1:0]  serve_y;
    logic                in_serve, in_play, visible;
    logic                wall_left, wall_top, wall_bot, paddle_hit, missed;
    logic                x_force, y_force;
    logic                x_set_pos, x_set_neg, y_set_pos, y_set_neg;

    assign x_r = x_l + COORD_W'(BALL_SIZE - 1);
    assign y_b = y_t + COORD_W'(BALL_SIZE - 1);

    assign paddle_sum = {1'b0, paddle_y_t} + {1'b0, paddle_y_b};
    assign serve_y    = paddle_sum[COORD_W:1] - COORD_W'(BALL_SIZE / 2);

    assign in_serve = (state == SERVE);
    assign in_play  = (state == PLAY);
    assign visible  = (state == SERVE) || (state == PLAY);

    assign wall_left  = (x_l <= COORD_W'(WALL_X_MIN + 1));
    assign wall_top   = (y_t <= COORD_W'(WALL_Y_MARGIN));
    assign wall_bot   = (y_b >= COORD_W'(SCREEN_H - 1 - WALL_Y_MARGIN));
    assign paddle_hit = (x_r >= COORD_W'(PADDLE_X_L)) && (x_r <= COORD_W'(PADDLE_X_L + 3)) &&
                        (y_b >= paddle_y_t) && (y_t <= paddle_y_b);
    assign missed     = (x_r >= COORD_W'(SCREEN_W - 2));

    // A wall or the paddle on an axis masks that axis' block hits entirely,
    // so it wins even when the block hit points the other way.
    assign x_force   = wall_left || paddle_hit;
    assign y_force   = wall_top || wall_bot;
    assign x_set_pos = in_play && (x_force ? wall_left  : hitR);
    assign x_set_neg = in_play && (x_force ? paddle_hit : hitL);
    assign y_set_pos = in_play && (y_force ? wall_top   : hitD);
    assign y_set_neg = in_play && (y_force ? wall_bot   : hitU);

    breakout_ball_axis #(
        .POS_INIT (PADDLE_X_L - BALL_SIZE - 2),
        .POS_MIN  (WALL_X_MIN),
        .POS_MAX  (SCREEN_W - BALL_SIZE),
        .STEP     (SPEED)
    ) u_x_axis (
        .clk      (clk),
        .reset    (reset),
        .load     (in_serve),
        .load_pos (SERVE_X),
        .step     (in_play && tick),
        .set_pos  (x_set_pos),
        .set_neg  (x_set_neg),
        .pos      (x_l)
    );

    breakout_ball_axis #(
        .POS_INIT (296),
        .POS_MIN  (0),
        .POS_MAX  (SCREEN_H - BALL_SIZE),
        .STEP     (SPEED)
    ) u_y_axis (
        .clk      (clk),
        .reset    (reset),
        .load     (in_serve),
        .load_pos (serve_y),
        .step     (in_play && tick),
        .set_pos  (y_set_pos),
        .set_neg  (y_set_neg),
        .pos      (y_t)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SERVE;
            lives     <= 3'(LIVES);
            hold_cnt  <= '0;
            game_over <= 1'b0;
        end else begin
            case (state)
                SERVE: begin
                    if (launch) begin
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    if (missed) begin
                        state <= MISS;
                        if (lives != 3'd0) begin
                            lives <= lives - 3'd1;
                        end
                    end
                end
                MISS: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_W'(MISS_HOLD - 1)) begin
                            hold_cnt <= '0;
                            if (lives == 3'd0) begin
                                state     <= OVER;
                                game_over <= 1'b1;
                            end else begin
                                state <= SERVE;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                OVER: begin
                    game_over <= 1'b1;
                end
                default: begin
                    state <= SERVE;
                end
            endcase
        end
    end

    assign ball_x_l = x_l;
    assign ball_x_r = x_r;
    assign ball_y_t = y_t;
    assign ball_y_b = y_b;
    assign ball_ON  = visible && (pix_x >= x_l) && (pix_x <= x_r) &&
                      (pix_y >= y_t) && (pix_y <= y_b);

endmodule

// File: tb/tb_breakout_ball_ctrl.sv
// tb_breakout_ball_ctrl: directed bench for breakout_ball_ctrl with
// hand-computed expected ball positions, directions, lives and game state.
module tb_breakout_ball_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        launch = 1'b0;
    logic        hitU = 1'b0, hitD = 1'b0, hitL = 1'b0, hitR = 1'b0;
    logic [10:0] paddle_y_t = 11'd280;
    logic [10:0] paddle_y_b = 11'd340;
    logic [10:0] pix_x = '0;
    logic [10:0] pix_y = '0;
    logic [10:0] ball_x_l, ball_x_r, ball_y_t, ball_y_b;
    logic        ball_ON;
    logic [2:0]  lives;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    breakout_ball_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .launch     (launch),
        .hitU       (hitU),
        .hitD       (hitD),
        .hitL       (hitL),
        .hitR       (hitR),
        .paddle_y_t (paddle_y_t),
        .paddle_y_b (paddle_y_b),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .ball_x_l   (ball_x_l),
        .ball_x_r   (ball_x_r),
        .ball_y_t   (ball_y_t),
        .ball_y_b   (ball_y_b),
        .ball_ON    (ball_ON),
        .lives      (lives),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
    endtask

    // Serve from y_t = 526 (paddle 500..560), steer right past a paddle that
    // has moved away, let the ball run out, then sit out the 60-tick hold.
    task automatic do_miss(input int exp_lives);
        launch = 1'b1;
        clk1();
        launch = 1'b0;
        paddle_y_t = 11'd100;
        paddle_y_b = 11'd120;
        hitR = 1'b1;
        clk1();
        hitR = 1'b0;
        for (int i = 0; i < 40 && ball_x_r < 11'd798; i++) do_tick();
        chk("miss_run_x_r", ball_x_r, 799);
        chk("miss_run_y_t", ball_y_t, 494);
        clk1();
        chk("miss_lives", lives, exp_lives);
        repeat (60) do_tick();
        paddle_y_t = 11'd500;
        paddle_y_b = 11'd560;
        clk1();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Asynchronous reset values.
        #1 reset = 1'b1;
        #1;
        chk("rst_x_l", ball_x_l, 760);
        chk("rst_x_r", ball_x_r, 767);
        chk("rst_y_t", ball_y_t, 296);
        chk("rst_lives", lives, 3);
        chk("rst_game_over", game_over, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // SERVE tracks the paddle centre: (280+340)/2 - 4 = 306.
        clk1();
        chk("serve_y_t", ball_y_t, 306);
        chk("serve_y_b", ball_y_b, 313);
        chk("serve_x_l", ball_x_l, 760);
        pix_x = 11'd760; pix_y = 11'd306; #1;
        chk("on_corner", ball_ON, 1);
        pix_x = 11'd768; #1;
        chk("off_right", ball_ON, 0);
        pix_x = 11'd767; pix_y = 11'd314; #1;
        chk("off_below", ball_ON, 0);

        // Hits are ignored outside PLAY.
        hitR = 1'b1;
        clk1();
        hitR = 1'b0;
        chk("serve_hit_ignored", dut.u_x_axis.dir, 0);

        // Launch, first tick moves left/up.
        launch = 1'b1;
        clk1();
        launch = 1'b0;
        do_tick();
        chk("tick1_x_l", ball_x_l, 758);
        chk("tick1_y_t", ball_y_t, 304);

        // Held hitR sets dx once and keeps it.
        hitR = 1'b1;
        clk1();
        chk("hitR_1clk", dut.u_x_axis.dir, 1);
        clk1();
        clk1();
        chk("hitR_3clk", dut.u_x_axis.dir, 1);
        hitL = 1'b1;
        clk1();
        hitR = 1'b0; hitL = 1'b0;
        chk("hitRL_hold", dut.u_x_axis.dir, 1);

        hitD = 1'b1;
        clk1();
        chk("hitD", dut.u_y_axis.dir, 1);
        hitU = 1'b1;
        clk1();
        chk("hitUD_hold", dut.u_y_axis.dir, 1);
        hitD = 1'b0;
        clk1();
        hitU = 1'b0;
        chk("hitU", dut.u_y_axis.dir, 0);

        // Tick and hit together: move with old dx, new dx afterwards.
        tick = 1'b1; hitL = 1'b1;
        clk1();
        tick = 1'b0; hitL = 1'b0;
        chk("tickhit_x_l", ball_x_l, 760);
        chk("tickhit_y_t", ball_y_t, 302);
        chk("tickhit_dx", dut.u_x_axis.dir, 0);
        hitR = 1'b1;
        clk1();
        hitR = 1'b0;

        // Reach the paddle face: x_l 764 -> x_r 771, y overlaps 280..340.
        do_tick();
        do_tick();
        chk("paddle_x_r", ball_x_r, 771);
        chk("paddle_y_t", ball_y_t, 298);
        hitR = 1'b1;
        clk1();
        hitR = 1'b0;
        chk("paddle_beats_hit", dut.u_x_axis.dir, 0);
        do_tick();
        chk("bounce_x_l", ball_x_l, 762);

        // Miss 1: paddle out of the way, ball runs to x_r = 799.
        paddle_y_t = 11'd500;
        paddle_y_b = 11'd560;
        hitR = 1'b1;
        clk1();
        hitR = 1'b0;
        for (int i = 0; i < 40 && ball_x_r < 11'd798; i++) do_tick();
        chk("miss1_x_r", ball_x_r, 799);
        chk("miss1_y_t", ball_y_t, 266);
        pix_x = 11'd792; pix_y = 11'd266; #1;
        chk("miss1_visible_play", ball_ON, 1);
        clk1();
        chk("miss1_lives", lives, 2);
        chk("miss1_hidden", ball_ON, 0);
        repeat (59) do_tick();
        chk("miss1_hold59_hidden", ball_ON, 0);
        chk("miss1_hold59_x_l", ball_x_l, 792);
        do_tick();
        clk1();
        chk("reserve_x_l", ball_x_l, 760);
        chk("reserve_y_t", ball_y_t, 526);
        chk("reserve_game_over", game_over, 0);
        pix_x = 11'd760; pix_y = 11'd526; #1;
        chk("reserve_visible", ball_ON, 1);

        // Misses 2 and 3 lead to OVER.
        do_miss(1);
        chk("miss2_x_l", ball_x_l, 760);
        do_miss(0);
        chk("over_game_over", game_over, 1);
        chk("over_x_l", ball_x_l, 792);
        pix_x = 11'd792; pix_y = 11'd494; #1;
        chk("over_hidden", ball_ON, 0);
        launch = 1'b1;
        repeat (3) clk1();
        launch = 1'b0;
        chk("over_launch_game_over", game_over, 1);
        chk("over_launch_lives", lives, 0);
        chk("over_launch_x_l", ball_x_l, 792);

        // Reset leaves OVER immediately.
        reset = 1'b1;
        #1;
        chk("rst2_lives", lives, 3);
        chk("rst2_game_over", game_over, 0);
        chk("rst2_x_l", ball_x_l, 760);
        @(posedge clk);
        #1 reset = 1'b0;

        // Top wall clamp: paddle 0..10 gives serve y_t = 1.
        paddle_y_t = 11'd0;
        paddle_y_b = 11'd10;
        clk1();
        chk("top_serve_y_t", ball_y_t, 1);
        launch = 1'b1;
        clk1();
        launch = 1'b0;
        do_tick();
        chk("top_clamp_y_t", ball_y_t, 0);
        chk("top_dy", dut.u_y_axis.dir, 1);
        do_tick();
        chk("top_next_y_t", ball_y_t, 2);
        chk("top_next_x_l", ball_x_l, 756);

        // Asynchronous reset between clock edges during PLAY.
        #3 reset = 1'b1;
        #1;
        chk("async_x_l", ball_x_l, 760);
        chk("async_y_t", ball_y_t, 296);
        chk("async_lives", lives, 3);
        @(posedge clk);
        #1 reset = 1'b0;
        clk1();
        chk("post_rst_serve_y_t", ball_y_t, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
